// File: rtl/pagerank_pkg.sv
// pagerank_pkg: shared state encoding and sizing helpers
// for the PageRank iteration scheduler.
package pagerank_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        ARB,
        GRANT,
        DRAIN,
        WAIT,
        EVAL
    } sched_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pagerank_iteration_scheduler_rr_arbiter.sv
// Round-robin pick: first requesting, unmasked thread at or
// above ptr, wrapping; purely combinational.
module pagerank_iteration_scheduler_rr_arbiter
    import pagerank_pkg::*;
#(
    parameter int N     = 8,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             valid_o
);

    logic [2*N-1:0] dbl;

    // Doubled vector turns the wrap-around search into a linear scan.
    assign dbl = {req_i & ~mask_i, req_i & ~mask_i};

    always_comb begin
        grant_o = '0;
        sel_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!valid_o && dbl[i] &&
                i >= int'(ptr_i) && i < int'(ptr_i) + N) begin
                grant_o[i % N] = 1'b1;
                sel_o          = SEL_W'(i % N);
                valid_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pagerank_iteration_scheduler.sv
// Sequences PageRank iterations: launches the partition engines, shares the
// serial final stage round-robin, then checks delta against epsilon.
module pagerank_iteration_scheduler
    import pagerank_pkg::*;
#(
    parameter int NUM_HW_THREADS = 8,
    parameter int ITER_W         = 16,
    parameter int DATA_W         = pagerank_pkg::DATA_W
) (
    input  logic                                   clock_i,
    input  logic                                   reset_n_i,
    input  logic                                   start_i,
    input  logic [DATA_W-1:0]                      epsilon_i,
    input  logic [ITER_W-1:0]                      max_iters_i,
    input  logic [NUM_HW_THREADS-1:0]              thread_req_i,
    input  logic [NUM_HW_THREADS-1:0]              thread_last_i,
    output logic [NUM_HW_THREADS-1:0]              thread_grant_o,
    output logic [sel_width(NUM_HW_THREADS)-1:0]   thread_sel_o,
    output logic                                   dmp_start_o,
    output logic                                   stream_start_o,
    output logic                                   stream_done_o,
    output logic                                   final_clear_o,
    input  logic                                   final_complete_i,
    input  logic [DATA_W-1:0]                      delta_i,
    output logic [ITER_W-1:0]                      iter_count_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   converged_o
);

    localparam int SEL_W = sel_width(NUM_HW_THREADS);
    localparam int CW    = ITER_W + 1;

    sched_state_t              state_q, state_d;
    logic [NUM_HW_THREADS-1:0] served_q, served_d;
    logic [NUM_HW_THREADS-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]          ptr_q, ptr_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic                      first_q, first_d;
    logic [DATA_W-1:0]         eps_q, eps_d;
    logic [DATA_W-1:0]         delta_q, delta_d;
    logic [ITER_W-1:0]         max_q, max_d;
    logic [ITER_W-1:0]         iter_q, iter_d;
    logic                      done_q, done_d;
    logic                      conv_q, conv_d;

    logic [NUM_HW_THREADS-1:0] arb_grant;
    logic [SEL_W-1:0]          arb_sel;
    logic                      arb_valid;

    pagerank_iteration_scheduler_rr_arbiter #(
        .N     (NUM_HW_THREADS),
        .SEL_W (SEL_W)
    ) u_arb (
        .req_i   (thread_req_i),
        .mask_i  (served_q),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .sel_o   (arb_sel),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        first_d  = first_q;
        eps_d    = eps_q;
        delta_d  = delta_q;
        max_d    = max_q;
        iter_d   = iter_q;
        done_d   = done_q;
        conv_d   = conv_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    eps_d   = epsilon_i;
                    max_d   = (max_iters_i == '0) ? ITER_W'(1) : max_iters_i;
                    done_d  = 1'b0;
                    conv_d  = 1'b0;
                    iter_d  = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR:  state_d = LAUNCH;
            LAUNCH: begin
                served_d = '0;
                first_d  = 1'b1;
                state_d  = ARB;
            end
            ARB: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    sel_d   = arb_sel;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                first_d = 1'b0;
                if (thread_last_i[sel_q]) begin
                    served_d = served_q | grant_q;
                    ptr_d    = (sel_q == SEL_W'(NUM_HW_THREADS - 1)) ?
                               '0 : sel_q + 1'b1;
                    grant_d  = '0;
                    sel_d    = '0;
                    state_d  = (served_d == '1) ? DRAIN : ARB;
                end
            end
            DRAIN: state_d = WAIT;
            WAIT: begin
                if (final_complete_i) begin
                    delta_d = delta_i;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (iter_q != '1) iter_d = iter_q + 1'b1;
                if (delta_q < eps_q) begin
                    conv_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (CW'(iter_q) + CW'(1) == CW'(max_q)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            served_q <= '0;
            grant_q  <= '0;
            ptr_q    <= '0;
            sel_q    <= '0;
            first_q  <= 1'b0;
            eps_q    <= '0;
            delta_q  <= '0;
            max_q    <= '0;
            iter_q   <= '0;
            done_q   <= 1'b0;
            conv_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            first_q  <= first_d;
            eps_q    <= eps_d;
            delta_q  <= delta_d;
            max_q    <= max_d;
            iter_q   <= iter_d;
            done_q   <= done_d;
            conv_q   <= conv_d;
        end
    end

    assign thread_grant_o = grant_q;
    assign thread_sel_o   = sel_q;
    assign dmp_start_o    = (state_q == LAUNCH);
    assign stream_start_o = (state_q == GRANT) && first_q;
    assign stream_done_o  = (state_q == DRAIN);
    assign final_clear_o  = (state_q == CLEAR);
    assign iter_count_o   = iter_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign converged_o    = conv_q;

endmodule

// File: tb/tb_pagerank_iteration_scheduler.sv
// Directed bench for pagerank_iteration_scheduler (4 threads) with a
// per-cycle grant/framing model and a run-level convergence model.
module tb_pagerank_iteration_scheduler;

    localparam int N  = 4;
    localparam int IW = 16;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] eps = '0;
    logic [IW-1:0] maxi = '0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  last_auto = '0;
    logic [N-1:0]  last_stray = '0;
    logic [N-1:0]  last;
    logic [N-1:0]  grant;
    logic [1:0]    sel;
    logic          dmp, ss, sd, fclr;
    logic          fc = 1'b0;
    logic [DW-1:0] delta = '0;
    logic [IW-1:0] iter;
    logic          busy, done, conv;

    assign last = last_auto | last_stray;

    always #5 clk = ~clk;

    pagerank_iteration_scheduler #(
        .NUM_HW_THREADS (N),
        .ITER_W         (IW),
        .DATA_W         (DW)
    ) dut (
        .clock_i          (clk),
        .reset_n_i        (rst_n),
        .start_i          (start),
        .epsilon_i        (eps),
        .max_iters_i      (maxi),
        .thread_req_i     (req),
        .thread_last_i    (last),
        .thread_grant_o   (grant),
        .thread_sel_o     (sel),
        .dmp_start_o      (dmp),
        .stream_start_o   (ss),
        .stream_done_o    (sd),
        .final_clear_o    (fclr),
        .final_complete_i (fc),
        .delta_i          (delta),
        .iter_count_o     (iter),
        .busy_o           (busy),
        .done_o           (done),
        .converged_o      (conv)
    );

    int vec = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r,
                                             input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    // Delta sequence returned by the final stage, one per iteration.
    logic [DW-1:0] dl [8];
    int            didx = 0;

    // Per-cycle model of arbitration and stream framing.
    logic [N-1:0] m_served = '0, prev_g = '0, prev_req = '0;
    int           m_ptr = 0;
    bit           m_first = 0, prev_hit = 0, prev_clr = 0, pend_sd = 0;
    bit           exp_ss;
    int           gq[$];
    int           ss_cnt = 0, sd_cnt = 0, dmp_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_served = '0;
            prev_g   = '0;
            prev_req = '0;
            m_ptr    = 0;
            m_first  = 0;
            prev_hit = 0;
            prev_clr = 0;
            pend_sd  = 0;
        end else begin
            exp_ss = 0;
            chk("grant_onehot", 64'($onehot0(grant)), 1);
            if (prev_g != '0) begin
                chk(prev_hit ? "grant_drop" : "grant_hold", grant,
                    prev_hit ? '0 : prev_g);
            end else if (grant != '0) begin
                chk("grant_rr", grant, rr_pick(prev_req & ~m_served, m_ptr));
                exp_ss  = m_first;
                m_first = 0;
                gq.push_back(idx(grant));
            end
            if (grant != '0) chk("sel", sel, idx(grant));
            chk("stream_start", ss, exp_ss);
            chk("stream_done", sd, pend_sd);
            chk("dmp_start", dmp, prev_clr);
            if (ss)  ss_cnt++;
            if (sd)  sd_cnt++;
            if (dmp) dmp_cnt++;
            pend_sd = 0;
            if (dmp) begin
                m_served = '0;
                m_first  = 1;
            end
            prev_hit = 0;
            if (grant != '0 && (last & grant) != '0) begin
                m_served = m_served | grant;
                m_ptr    = (idx(grant) + 1) % N;
                prev_hit = 1;
                pend_sd  = (m_served == '1);
            end
            prev_g   = grant;
            prev_req = req;
            prev_clr = fclr;
        end
    end

    // Partition engines: each grant lasts three beats.
    initial begin : thread_model
        int beat;
        beat = 0;
        forever begin
            @(posedge clk); #1;
            last_auto = '0;
            if (grant != '0) begin
                if (beat == 2) begin
                    last_auto = grant;
                    beat = 0;
                end else beat++;
            end else beat = 0;
        end
    end

    // Final stage: reports delta two cycles after stream_done.
    initial begin : final_model
        forever begin
            @(posedge clk); #1;
            if (sd && rst_n) begin
                repeat (2) @(posedge clk);
                #1;
                delta = dl[didx];
                if (didx < 7) didx++;
                fc = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                fc = 1'b0;
            end
        end
    end

    function automatic void model_run(input logic [DW-1:0] e,
                                      input logic [IW-1:0] m,
                                      output int it, output bit cv);
        int cap;
        cap = (m == '0) ? 1 : int'(m);
        it  = 0;
        cv  = 0;
        for (int i = 0; i < 64; i++) begin
            it++;
            if (dl[(i < 7) ? i : 7] < e) begin
                cv = 1;
                return;
            end
            if (it == cap) return;
        end
    endfunction

    task automatic start_run(input logic [DW-1:0] e, input logic [IW-1:0] m);
        gq.delete();
        ss_cnt = 0;
        sd_cnt = 0;
        dmp_cnt = 0;
        didx = 0;
        eps = e;
        maxi = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string n);
        int c;
        c = 0;
        while (!done && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        chk({n, "_done_timeout"}, done, 1);
    endtask

    task automatic wait_gq(input string n, input int k);
        int c;
        c = 0;
        while (gq.size() < k && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        chk({n, "_grant_timeout"}, 64'(gq.size() >= k), 1);
    endtask

    task automatic wait_sd(input string n, input int k);
        int c;
        c = 0;
        while (sd_cnt < k && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        chk({n, "_sd_timeout"}, 64'(sd_cnt >= k), 1);
    endtask

    task automatic run_check(input string n, input int lit_it,
                             input bit lit_cv);
        int it;
        bit cv;
        model_run(eps, maxi, it, cv);
        chk({n, "_iter"}, iter, it);
        chk({n, "_conv"}, conv, cv);
        chk({n, "_iter_lit"}, iter, lit_it);
        chk({n, "_conv_lit"}, conv, lit_cv);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_ss_cnt"}, ss_cnt, it);
        chk({n, "_sd_cnt"}, sd_cnt, it);
        chk({n, "_dmp_cnt"}, dmp_cnt, it);
    endtask

    task automatic chk_order(input string n, input int exp[8]);
        chk({n, "_ngrants"}, gq.size(), 8);
        for (int i = 0; i < 8; i++)
            chk({n, "_order"}, (i < gq.size()) ? gq[i] : -1, exp[i]);
    endtask

    initial begin
        int o1[8];
        int o2[8];
        for (int i = 0; i < 8; i++) dl[i] = 64'd500;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_conv", conv, 0);
        chk("rst_grant", grant, 0);
        chk("rst_iter", iter, 0);
        chk("rst_dmp", dmp, 0);
        chk("rst_clear", fclr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Run 1: all threads ready, converges on second iteration.
        req = 4'b1111;
        dl[0] = 64'd250;
        dl[1] = 64'd40;
        start_run(64'd100, 16'd10);
        chk("t1_final_clear", fclr, 1);
        chk("t1_busy", busy, 1);
        @(posedge clk); #1;
        chk("t1_dmp_latency", dmp, 1);
        wait_done("t1");
        o1 = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_order("t1", o1);
        run_check("t1", 2, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_done_hold", done, 1);
        chk("t1_conv_hold", conv, 1);

        // Run 2: staggered requests, pointer carry-over, stray last.
        req = 4'b1110;
        dl[0] = 64'd500;
        dl[1] = 64'd10;
        start_run(64'd100, 16'd10);
        wait_gq("t2a", 3);
        req = 4'b1111;
        wait_sd("t2", 1);
        req = 4'b0101;
        wait_gq("t2b", 6);
        req = 4'b1111;
        wait_gq("t2c", 7);
        last_stray = 4'b1000;
        @(posedge clk); #1;
        last_stray = 4'b0000;
        chk("t2_stray_hold", grant, 4'b0010);
        wait_done("t2");
        o2 = '{1, 2, 3, 0, 2, 0, 1, 3};
        chk_order("t2", o2);
        run_check("t2", 2, 1);

        // Run 3: never converges, capped at 3; start during WAIT ignored.
        for (int i = 0; i < 8; i++) dl[i] = 64'd500;
        req = 4'b1111;
        start_run(64'd100, 16'd3);
        wait_sd("t3", 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t3");
        run_check("t3", 3, 0);

        // Run 4: max_iters of zero behaves as one.
        start_run(64'd100, 16'd0);
        wait_done("t4");
        run_check("t4", 1, 0);

        // Run 5: asynchronous reset while thread 1 holds the grant.
        dl[0] = 64'd10;
        start_run(64'd100, 16'd10);
        begin
            int c;
            c = 0;
            while (grant != 4'b0010 && c < 500) begin
                @(posedge clk); #1;
                c++;
            end
            chk("t5_grant1_timeout", grant, 4'b0010);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", grant, 0);
        chk("t5_async_sel", sel, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_iter", iter, 0);
        chk("t5_async_ss", ss, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_run(64'd100, 16'd10);
        wait_done("t6");
        chk("t6_first_grant", (gq.size() > 0) ? gq[0] : -1, 0);
        run_check("t6", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
